// File: rtl/axi_enhanced_tx_trn_arbiter.sv
// Packet-granular round-robin arbiter that shares one TRN TX port between
// C_NUM_REQ TLP sources; the owner keeps the port from tsof through teof or dsc.
module axi_enhanced_tx_trn_arbiter #(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_NUM_REQ    = 3,
  parameter int TCQ          = 1,
  parameter int REM_WIDTH    = (C_DATA_WIDTH == 128) ? 2 : 1,
  parameter int IDX_WIDTH    = 3
) (
  input  logic                              com_iclk,
  input  logic                              com_sysrst,
  input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_td,
  input  logic [C_NUM_REQ-1:0]              req_tsof,
  input  logic [C_NUM_REQ-1:0]              req_teof,
  input  logic [C_NUM_REQ-1:0]              req_tsrc_rdy,
  input  logic [C_NUM_REQ-1:0]              req_tsrc_dsc,
  input  logic [C_NUM_REQ*REM_WIDTH-1:0]    req_trem,
  output logic [C_NUM_REQ-1:0]              req_tdst_rdy,
  output logic [C_DATA_WIDTH-1:0]           trn_td,
  output logic                              trn_tsof,
  output logic                              trn_teof,
  output logic                              trn_tsrc_rdy,
  output logic                              trn_tsrc_dsc,
  output logic [REM_WIDTH-1:0]              trn_trem,
  input  logic                              trn_tdst_rdy,
  output logic [C_NUM_REQ-1:0]              arb_grant,
  output logic                              arb_proto_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  // TCQ is kept for interface compatibility; registers here carry no delay.
  if (C_NUM_REQ < 2 || C_NUM_REQ > 8 || (1 << IDX_WIDTH) < C_NUM_REQ || TCQ < 0) begin : g_param_check
    $error("axi_enhanced_tx_trn_arbiter: illegal parameter combination");
  end

  logic [0:0]              state;
  logic [C_NUM_REQ-1:0]    grant;
  logic [IDX_WIDTH-1:0]    idx;
  logic [IDX_WIDTH-1:0]    rr_ptr;
  logic                    first_beat;
  logic                    proto_err;

  logic [C_NUM_REQ-1:0]    req_vec;
  logic [C_NUM_REQ-1:0]    req_rot;
  logic [C_NUM_REQ-1:0]    pick_onehot;
  logic [IDX_WIDTH-1:0]    pick_idx;
  logic                    found;
  int                      cand;

  logic [C_DATA_WIDTH-1:0] own_td;
  logic                    own_tsof;
  logic                    own_teof;
  logic                    own_rdy;
  logic                    own_dsc;
  logic [REM_WIDTH-1:0]    own_trem;
  logic                    xfer_beat;
  logic                    pkt_end;

  assign req_vec = req_tsof & req_tsrc_rdy;

  // Search upward from the last owner + 1, wrapping, so every source gets a turn.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    cand     = 0;
    req_rot  = '0;
    for (int k = 1; k <= C_NUM_REQ; k++) begin
      cand    = (int'(rr_ptr) + k) % C_NUM_REQ;
      req_rot = req_vec >> cand;
      if (!found && req_rot[0]) begin
        found    = 1'b1;
        pick_idx = IDX_WIDTH'(cand);
      end
    end
  end

  assign pick_onehot = {{(C_NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;

  always_comb begin
    own_td   = '0;
    own_tsof = 1'b0;
    own_teof = 1'b0;
    own_rdy  = 1'b0;
    own_dsc  = 1'b0;
    own_trem = '0;
    if (state == ST_XFER) begin
      for (int i = 0; i < C_NUM_REQ; i++) begin
        if (idx == IDX_WIDTH'(i)) begin
          own_td   = req_td[i*C_DATA_WIDTH +: C_DATA_WIDTH];
          own_tsof = req_tsof[i];
          own_teof = req_teof[i];
          own_rdy  = req_tsrc_rdy[i];
          own_dsc  = req_tsrc_dsc[i];
          own_trem = req_trem[i*REM_WIDTH +: REM_WIDTH];
        end
      end
    end
  end

  assign xfer_beat = own_rdy && trn_tdst_rdy;
  assign pkt_end   = own_dsc || (xfer_beat && own_teof);

  // Outputs derive from state, so an async reset clears them without a clock.
  assign trn_td        = own_td;
  assign trn_tsof      = own_tsof;
  assign trn_teof      = own_teof;
  assign trn_tsrc_rdy  = own_rdy;
  assign trn_tsrc_dsc  = own_dsc;
  assign trn_trem      = own_trem;
  assign req_tdst_rdy  = (state == ST_XFER) ? (grant & {C_NUM_REQ{trn_tdst_rdy}}) : '0;
  assign arb_grant     = grant;
  assign arb_proto_err = proto_err;

  always_ff @(posedge com_iclk or posedge com_sysrst) begin
    if (com_sysrst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      idx        <= '0;
      rr_ptr     <= IDX_WIDTH'(C_NUM_REQ - 1);
      first_beat <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      proto_err <= xfer_beat && own_tsof && !first_beat;
      if (state == ST_IDLE) begin
        if (found) begin
          grant      <= pick_onehot;
          idx        <= pick_idx;
          first_beat <= 1'b1;
          state      <= ST_XFER;
        end
      end else begin
        if (xfer_beat) begin
          first_beat <= 1'b0;
        end
        if (pkt_end) begin
          rr_ptr <= idx;
          grant  <= '0;
          state  <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_enhanced_tx_trn_arbiter.sv
// Directed bench for the TRN TX arbiter: arbitration order, stalls, discontinue,
// protocol-error pulse and asynchronous reset.
module tb_axi_enhanced_tx_trn_arbiter;

  localparam int W   = 128;
  localparam int N   = 3;
  localparam int RW  = 2;

  logic            com_iclk = 1'b0;
  logic            com_sysrst;
  logic [N*W-1:0]  req_td;
  logic [N-1:0]    req_tsof, req_teof, req_tsrc_rdy, req_tsrc_dsc;
  logic [N*RW-1:0] req_trem;
  logic [N-1:0]    req_tdst_rdy;
  logic [W-1:0]    trn_td;
  logic            trn_tsof, trn_teof, trn_tsrc_rdy, trn_tsrc_dsc;
  logic [RW-1:0]   trn_trem;
  logic            trn_tdst_rdy;
  logic [N-1:0]    arb_grant;
  logic            arb_proto_err;

  logic [W-1:0]    td_a   [N];
  logic [RW-1:0]   trem_a [N];

  int checks   = 0;
  int failures = 0;

  always #5 com_iclk = ~com_iclk;

  always_comb begin
    req_td   = '0;
    req_trem = '0;
    for (int i = 0; i < N; i++) begin
      req_td[i*W +: W]    = td_a[i];
      req_trem[i*RW +: RW] = trem_a[i];
    end
  end

  axi_enhanced_tx_trn_arbiter #(
    .C_DATA_WIDTH(W), .C_NUM_REQ(N), .TCQ(1)
  ) dut (
    .com_iclk(com_iclk), .com_sysrst(com_sysrst),
    .req_td(req_td), .req_tsof(req_tsof), .req_teof(req_teof),
    .req_tsrc_rdy(req_tsrc_rdy), .req_tsrc_dsc(req_tsrc_dsc), .req_trem(req_trem),
    .req_tdst_rdy(req_tdst_rdy),
    .trn_td(trn_td), .trn_tsof(trn_tsof), .trn_teof(trn_teof),
    .trn_tsrc_rdy(trn_tsrc_rdy), .trn_tsrc_dsc(trn_tsrc_dsc), .trn_trem(trn_trem),
    .trn_tdst_rdy(trn_tdst_rdy),
    .arb_grant(arb_grant), .arb_proto_err(arb_proto_err)
  );

  task automatic drive(input int r, input logic [W-1:0] d, input logic sof, input logic eof,
                       input logic rdy, input logic dsc, input logic [RW-1:0] rem);
    td_a[r]         = d;
    req_tsof[r]     = sof;
    req_teof[r]     = eof;
    req_tsrc_rdy[r] = rdy;
    req_tsrc_dsc[r] = dsc;
    trem_a[r]       = rem;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) drive(i, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic next();
    @(posedge com_iclk);
    #1;
  endtask

  task automatic do_reset();
    com_sysrst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge com_iclk);
    #1;
    com_sysrst = 1'b0;
  endtask

  task automatic test_reset();
    com_sysrst   = 1'b1;
    trn_tdst_rdy = 1'b1;
    clear_inputs();
    drive(0, 128'hAA, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b000 || trn_tsrc_rdy !== 1'b0 || req_tdst_rdy !== 3'b000 ||
        trn_td !== '0 || arb_proto_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got grant=%b rdy=%b tdst=%b err=%b exp all zero",
               arb_grant, trn_tsrc_rdy, req_tdst_rdy, arb_proto_err);
    end
    clear_inputs();
    next();
    com_sysrst = 1'b0;
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b000 || trn_tsrc_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle got grant=%b rdy=%b exp 000/0", arb_grant, trn_tsrc_rdy);
    end
  endtask

  task automatic test_single_req();
    do_reset();
    trn_tdst_rdy = 1'b1;
    drive(1, 128'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b000 || trn_tsrc_rdy !== 1'b0) begin
      failures++;
      $display("FAIL t1_arb_cycle got grant=%b rdy=%b exp 000/0", arb_grant, trn_tsrc_rdy);
    end
    next();
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b010 || trn_td !== 128'hA1 || trn_tsof !== 1'b1 || trn_teof !== 1'b0 ||
        trn_tsrc_rdy !== 1'b1 || req_tdst_rdy !== 3'b010) begin
      failures++;
      $display("FAIL t1_beat1 got grant=%b td=%h sof=%b eof=%b tdst=%b exp 010/a1/1/0/010",
               arb_grant, trn_td, trn_tsof, trn_teof, req_tdst_rdy);
    end
    next();
    drive(1, 128'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge com_iclk);
    checks++;
    if (trn_td !== 128'hA2 || trn_tsof !== 1'b0 || trn_teof !== 1'b0 || arb_grant !== 3'b010) begin
      failures++;
      $display("FAIL t1_beat2 got td=%h sof=%b eof=%b grant=%b exp a2/0/0/010",
               trn_td, trn_tsof, trn_teof, arb_grant);
    end
    next();
    drive(1, 128'hA3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
    @(negedge com_iclk);
    checks++;
    if (trn_td !== 128'hA3 || trn_teof !== 1'b1 || trn_trem !== 2'b01) begin
      failures++;
      $display("FAIL t1_beat3 got td=%h eof=%b rem=%b exp a3/1/01", trn_td, trn_teof, trn_trem);
    end
    next();
    drive(1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b000 || trn_tsrc_rdy !== 1'b0) begin
      failures++;
      $display("FAIL t1_after got grant=%b rdy=%b exp 000/0", arb_grant, trn_tsrc_rdy);
    end
  endtask

  task automatic send_pkts(input int r, input int npkt);
    for (int p = 0; p < npkt; p++) begin
      for (int b = 0; b < 2; b++) begin
        bit done;
        done = 1'b0;
        drive(r, {8'(r), 120'(p*2 + b)}, (b == 0), (b == 1), 1'b1, 1'b0, 2'b11);
        for (int w = 0; w < 60 && !done; w++) begin
          @(negedge com_iclk);
          if (req_tdst_rdy[r]) done = 1'b1;
          next();
        end
        if (!done) begin
          failures++;
          $display("FAIL t2_sender%0d_timeout got no tdst_rdy exp grant within 60 cycles", r);
        end
      end
    end
    drive(r, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_round_robin();
    int order [6];
    order = '{0, 1, 2, 0, 1, 2};
    do_reset();
    trn_tdst_rdy = 1'b1;
    fork
      send_pkts(0, 2);
      send_pkts(1, 2);
      send_pkts(2, 2);
      begin
        for (int n = 0; n < 18; n++) begin
          logic [N-1:0] exp_g;
          logic         exp_v;
          @(negedge com_iclk);
          exp_v = (n % 3 != 0);
          exp_g = exp_v ? (3'b001 << order[n/3]) : 3'b000;
          checks++;
          if (arb_grant !== exp_g || trn_tsrc_rdy !== exp_v ||
              (exp_v && trn_td[127:120] !== 8'(order[n/3]))) begin
            failures++;
            $display("FAIL t2_rr_cycle%0d got grant=%b rdy=%b id=%0d exp grant=%b rdy=%b",
                     n, arb_grant, trn_tsrc_rdy, trn_td[127:120], exp_g, exp_v);
          end
        end
      end
    join
  endtask

  task automatic test_stall();
    logic         pat [5];
    logic [W-1:0] dat [3];
    int           beat;
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    dat  = '{128'hB1, 128'hB2, 128'hB3};
    beat = 0;
    next();
    trn_tdst_rdy = 1'b1;
    drive(0, dat[0], 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b000) begin
      failures++;
      $display("FAIL t3_arb_cycle got grant=%b exp 000", arb_grant);
    end
    next();
    for (int t = 0; t < 5; t++) begin
      trn_tdst_rdy = pat[t];
      drive(0, dat[beat], (beat == 0), (beat == 2), 1'b1, 1'b0, 2'b10);
      @(negedge com_iclk);
      checks++;
      if (req_tdst_rdy !== {2'b00, pat[t]} || trn_td !== dat[beat] || arb_grant !== 3'b001) begin
        failures++;
        $display("FAIL t3_stall_t%0d got tdst=%b td=%h grant=%b exp tdst=%b td=%h grant=001",
                 t, req_tdst_rdy, trn_td, arb_grant, {2'b00, pat[t]}, dat[beat]);
      end
      next();
      if (pat[t]) beat++;
    end
    drive(0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    trn_tdst_rdy = 1'b1;
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b000 || beat != 3) begin
      failures++;
      $display("FAIL t3_done got grant=%b beats=%0d exp 000/3", arb_grant, beat);
    end
  endtask

  task automatic test_discontinue();
    next();
    trn_tdst_rdy = 1'b1;
    drive(2, 128'hD1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge com_iclk);
    next();
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b100 || trn_td !== 128'hD1) begin
      failures++;
      $display("FAIL t4_grant2 got grant=%b td=%h exp 100/d1", arb_grant, trn_td);
    end
    next();
    drive(2, 128'hD2, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    @(negedge com_iclk);
    checks++;
    if (trn_tsrc_dsc !== 1'b1 || arb_grant !== 3'b100) begin
      failures++;
      $display("FAIL t4_dsc got dsc=%b grant=%b exp 1/100", trn_tsrc_dsc, arb_grant);
    end
    next();
    drive(2, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(0, 128'hE0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
    drive(1, 128'hE1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b000 || trn_tsrc_dsc !== 1'b0) begin
      failures++;
      $display("FAIL t4_idle got grant=%b dsc=%b exp 000/0", arb_grant, trn_tsrc_dsc);
    end
    next();
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b001 || trn_tsof !== 1'b1 || trn_teof !== 1'b1 || trn_td !== 128'hE0) begin
      failures++;
      $display("FAIL t4_next_req0 got grant=%b sof=%b eof=%b td=%h exp 001/1/1/e0",
               arb_grant, trn_tsof, trn_teof, trn_td);
    end
    next();
    drive(0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b000) begin
      failures++;
      $display("FAIL t4_single_beat_end got grant=%b exp 000", arb_grant);
    end
    next();
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b010 || trn_td !== 128'hE1) begin
      failures++;
      $display("FAIL t4_next_req1 got grant=%b td=%h exp 010/e1", arb_grant, trn_td);
    end
    next();
    drive(1, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_proto_err();
    trn_tdst_rdy = 1'b1;
    drive(0, 128'hC1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge com_iclk);
    checks++;
    if (arb_proto_err !== 1'b0 || arb_grant !== 3'b000) begin
      failures++;
      $display("FAIL t5_idle got err=%b grant=%b exp 0/000", arb_proto_err, arb_grant);
    end
    next();
    @(negedge com_iclk);
    checks++;
    if (arb_proto_err !== 1'b0 || arb_grant !== 3'b001) begin
      failures++;
      $display("FAIL t5_beat1 got err=%b grant=%b exp 0/001", arb_proto_err, arb_grant);
    end
    next();
    drive(0, 128'hC2, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge com_iclk);
    checks++;
    if (arb_proto_err !== 1'b0 || trn_tsof !== 1'b1 || trn_td !== 128'hC2 || arb_grant !== 3'b001) begin
      failures++;
      $display("FAIL t5_beat2_fwd got err=%b sof=%b td=%h grant=%b exp 0/1/c2/001",
               arb_proto_err, trn_tsof, trn_td, arb_grant);
    end
    next();
    drive(0, 128'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    @(negedge com_iclk);
    checks++;
    if (arb_proto_err !== 1'b1 || trn_td !== 128'hC3 || arb_grant !== 3'b001) begin
      failures++;
      $display("FAIL t5_err_pulse got err=%b td=%h grant=%b exp 1/c3/001",
               arb_proto_err, trn_td, arb_grant);
    end
    next();
    drive(0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1, 128'hC4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    @(negedge com_iclk);
    checks++;
    if (arb_proto_err !== 1'b0 || arb_grant !== 3'b000) begin
      failures++;
      $display("FAIL t5_err_clear got err=%b grant=%b exp 0/000", arb_proto_err, arb_grant);
    end
    next();
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b010 || arb_proto_err !== 1'b0) begin
      failures++;
      $display("FAIL t5_continue got grant=%b err=%b exp 010/0", arb_grant, arb_proto_err);
    end
    next();
    drive(1, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge com_iclk);
    checks++;
    if (arb_proto_err !== 1'b0 || arb_grant !== 3'b000) begin
      failures++;
      $display("FAIL t5_legal_single got err=%b grant=%b exp 0/000", arb_proto_err, arb_grant);
    end
  endtask

  task automatic test_async_reset();
    next();
    trn_tdst_rdy = 1'b1;
    drive(2, 128'hF1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge com_iclk);
    next();
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b100 || trn_tsrc_rdy !== 1'b1) begin
      failures++;
      $display("FAIL t6_owner got grant=%b rdy=%b exp 100/1", arb_grant, trn_tsrc_rdy);
    end
    #2;
    com_sysrst = 1'b1;
    #1;
    checks++;
    if (trn_tsrc_rdy !== 1'b0 || arb_grant !== 3'b000 || req_tdst_rdy !== 3'b000) begin
      failures++;
      $display("FAIL t6_async_drop got rdy=%b grant=%b tdst=%b exp 0/000/000",
               trn_tsrc_rdy, arb_grant, req_tdst_rdy);
    end
    drive(0, 128'hF0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    drive(1, 128'hF2, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge com_iclk);
    com_sysrst = 1'b0;
    @(negedge com_iclk);
    checks++;
    if (arb_grant !== 3'b001 || trn_td !== 128'hF0) begin
      failures++;
      $display("FAIL t6_post_reset_prio got grant=%b td=%h exp 001/f0", arb_grant, trn_td);
    end
    clear_inputs();
  endtask

  initial begin
    com_sysrst   = 1'b1;
    trn_tdst_rdy = 1'b0;
    clear_inputs();
    test_reset();
    test_single_req();
    test_round_robin();
    test_stall();
    test_discontinue();
    test_proto_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish exp finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
